hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard.sv | 89 ++++++++
 tb/tb_hazard_scoreboard.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Two-slot (EX/MEM) destination scoreboard for an in-order pipeline: detects RAW
// hazards at decode, requests a stall/bubble, and counts stall cycles.
module hazard_scoreboard (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [2:0]  id_Rs,
  input  logic [2:0]  id_Rt,
  input  logic        id_Rs_valid,
  input  logic        id_Rt_valid,
  input  logic [2:0]  id_Rd,
  input  logic        id_Rd_valid,
  input  logic        flush,
  input  logic        mem_stall,
  input  logic        cnt_clr,
  output logic        stall,
  output logic [2:0]  ex_dest,
  output logic        ex_dest_valid,
  output logic [2:0]  mem_dest,
  output logic        mem_dest_valid,
  output logic [15:0] stall_count
);

  logic [2:0]  ex_dest_q, ex_dest_d;
  logic        ex_valid_q, ex_valid_d;
  logic [2:0]  mem_dest_q, mem_dest_d;
  logic        mem_valid_q, mem_valid_d;
  logic [15:0] count_q, count_d;
  logic        rs_hit, rt_hit;

  // WB is not tracked: the register file forwards same-cycle writes to reads.
  always_comb begin
    rs_hit = id_Rs_valid & ((ex_valid_q & (id_Rs == ex_dest_q)) |
                            (mem_valid_q & (id_Rs == mem_dest_q)));
    rt_hit = id_Rt_valid & ((ex_valid_q & (id_Rt == ex_dest_q)) |
                            (mem_valid_q & (id_Rt == mem_dest_q)));
    stall  = id_valid & ~flush & (rs_hit | rt_hit);
  end

  always_comb begin
    ex_dest_d   = ex_dest_q;
    ex_valid_d  = ex_valid_q;
    mem_dest_d  = mem_dest_q;
    mem_valid_d = mem_valid_q;
    if (!mem_stall) begin
      mem_dest_d  = ex_dest_q;
      mem_valid_d = ex_valid_q;
      if (id_valid && !flush && !stall) begin
        ex_dest_d  = id_Rd;
        ex_valid_d = id_Rd_valid;
      end else begin
        ex_dest_d  = 3'b000;
        ex_valid_d = 1'b0;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (cnt_clr) begin
      count_d = 16'h0000;
    end else if (stall && !mem_stall && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_dest_q   <= 3'b000;
      ex_valid_q  <= 1'b0;
      mem_dest_q  <= 3'b000;
      mem_valid_q <= 1'b0;
      count_q     <= 16'h0000;
    end else begin
      ex_dest_q   <= ex_dest_d;
      ex_valid_q  <= ex_valid_d;
      mem_dest_q  <= mem_dest_d;
      mem_valid_q <= mem_valid_d;
      count_q     <= count_d;
    end
  end

  assign ex_dest        = ex_dest_q;
  assign ex_dest_valid  = ex_valid_q;
  assign mem_dest       = mem_dest_q;
  assign mem_dest_valid = mem_valid_q;
  assign stall_count    = count_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: each task drives one scenario and checks inline.
module tb_hazard_scoreboard;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [2:0]  id_Rs, id_Rt, id_Rd;
  logic        id_Rs_valid, id_Rt_valid, id_Rd_valid;
  logic        flush, mem_stall, cnt_clr;
  logic        stall;
  logic [2:0]  ex_dest, mem_dest;
  logic        ex_dest_valid, mem_dest_valid;
  logic [15:0] stall_count;

  int n_checks = 0;
  int n_fail   = 0;

  hazard_scoreboard dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_valid       (id_valid),
    .id_Rs          (id_Rs),
    .id_Rt          (id_Rt),
    .id_Rs_valid    (id_Rs_valid),
    .id_Rt_valid    (id_Rt_valid),
    .id_Rd          (id_Rd),
    .id_Rd_valid    (id_Rd_valid),
    .flush          (flush),
    .mem_stall      (mem_stall),
    .cnt_clr        (cnt_clr),
    .stall          (stall),
    .ex_dest        (ex_dest),
    .ex_dest_valid  (ex_dest_valid),
    .mem_dest       (mem_dest),
    .mem_dest_valid (mem_dest_valid),
    .stall_count    (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change just after the falling edge; checks happen 1 time unit later.
  task automatic set_id(input logic v, input logic [2:0] rs, input logic rsv,
                        input logic [2:0] rt, input logic rtv,
                        input logic [2:0] rd, input logic rdv);
    id_valid = v; id_Rs = rs; id_Rs_valid = rsv; id_Rt = rt; id_Rt_valid = rtv;
    id_Rd = rd; id_Rd_valid = rdv;
    #1;
  endtask

  task automatic idle();
    set_id(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; mem_stall = 1'b0; cnt_clr = 1'b0;
    set_id(1'b1, 3'd0, 1'b1, 3'd0, 1'b1, 3'd1, 1'b1);
    @(negedge clk); #1;
    n_checks++; if (ex_dest_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ex_valid got %b want 0", ex_dest_valid); end
    n_checks++; if (mem_dest_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mem_valid got %b want 0", mem_dest_valid); end
    n_checks++; if (stall_count !== 16'h0) begin n_fail++; $display("FAIL reset_count got %h want 0000", stall_count); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", stall); end
    rst_n = 1'b1;
    idle();
  endtask

  task automatic test_back_to_back();
    set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1);
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL b2b_prod_stall got %b want 0", stall); end
    tick();
    n_checks++; if ({ex_dest_valid, ex_dest} !== 4'b1011) begin n_fail++; $display("FAIL b2b_ex_load got %b want 1011", {ex_dest_valid, ex_dest}); end
    set_id(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd4, 1'b1);
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL b2b_stall1 got %b want 1", stall); end
    tick();
    n_checks++; if ({stall, ex_dest_valid, mem_dest_valid, mem_dest} !== 6'b101011) begin n_fail++; $display("FAIL b2b_stall2 got %b want 101011", {stall, ex_dest_valid, mem_dest_valid, mem_dest}); end
    tick();
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL b2b_release got %b want 0", stall); end
    n_checks++; if (stall_count !== 16'd2) begin n_fail++; $display("FAIL b2b_count got %0d want 2", stall_count); end
    tick();
    idle();
    n_checks++; if ({ex_dest_valid, ex_dest} !== 4'b1100) begin n_fail++; $display("FAIL b2b_consumer_ex got %b want 1100", {ex_dest_valid, ex_dest}); end
    tick(); tick();
  endtask

  task automatic test_one_between();
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    n_checks++; if (stall_count !== 16'd0) begin n_fail++; $display("FAIL clr_count got %0d want 0", stall_count); end
    set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1);
    tick();
    // Reads and writes r6 itself; its own destination must not stall it.
    set_id(1'b1, 3'd6, 1'b1, 3'd1, 1'b1, 3'd6, 1'b1);
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL gap1_indep got %b want 0", stall); end
    tick();
    set_id(1'b1, 3'd0, 1'b0, 3'd5, 1'b1, 3'd0, 1'b0);
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL gap1_stall got %b want 1", stall); end
    tick();
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL gap1_release got %b want 0", stall); end
    n_checks++; if (stall_count !== 16'd1) begin n_fail++; $display("FAIL gap1_count got %0d want 1", stall_count); end
    // Two instructions between: r6 now sits past MEM.
    tick();
    set_id(1'b1, 3'd6, 1'b1, 3'd6, 1'b1, 3'd0, 1'b0);
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL gap2_nostall got %b want 0", stall); end
    idle(); tick(); tick();
  endtask

  task automatic test_flush();
    set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1);
    tick();
    flush = 1'b1;
    set_id(1'b1, 3'd2, 1'b1, 3'd0, 1'b0, 3'd7, 1'b1);
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall got %b want 0", stall); end
    tick();
    flush = 1'b0;
    idle();
    n_checks++; if ({ex_dest_valid, mem_dest_valid, mem_dest} !== 5'b01010) begin n_fail++; $display("FAIL flush_bubble got %b want 01010", {ex_dest_valid, mem_dest_valid, mem_dest}); end
    n_checks++; if (stall_count !== 16'd1) begin n_fail++; $display("FAIL flush_count got %0d want 1", stall_count); end
    tick(); tick();
  endtask

  task automatic test_mem_stall();
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1);
    tick();
    mem_stall = 1'b1;
    set_id(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 3'd7, 1'b1);
    for (int i = 0; i < 4; i++) begin
      n_checks++; if ({stall, ex_dest_valid, ex_dest, mem_dest_valid} !== 6'b110010) begin n_fail++; $display("FAIL frz_cycle%0d got %b want 110010", i, {stall, ex_dest_valid, ex_dest, mem_dest_valid}); end
      tick();
    end
    n_checks++; if (stall_count !== 16'd0) begin n_fail++; $display("FAIL frz_count got %0d want 0", stall_count); end
    mem_stall = 1'b0; #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL frz_rel1 got %b want 1", stall); end
    tick();
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL frz_rel2 got %b want 1", stall); end
    tick();
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL frz_rel3 got %b want 0", stall); end
    n_checks++; if (stall_count !== 16'd2) begin n_fail++; $display("FAIL frz_count2 got %0d want 2", stall_count); end
    tick();
    idle();
    n_checks++; if ({ex_dest_valid, ex_dest} !== 4'b1111) begin n_fail++; $display("FAIL frz_consumer_ex got %b want 1111", {ex_dest_valid, ex_dest}); end
    tick(); tick();
  endtask

  task automatic test_both_match();
    // r1 reaches MEM while r2 sits in EX; Rs hits MEM, Rt hits EX.
    set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1); tick();
    set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1); tick();
    set_id(1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 3'd0, 1'b0);
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL both_stall1 got %b want 1", stall); end
    tick();
    n_checks++; if ({stall, mem_dest} !== 4'b1010) begin n_fail++; $display("FAIL both_stall2 got %b want 1010", {stall, mem_dest}); end
    tick();
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL both_release got %b want 0", stall); end
    idle(); tick(); tick();
  endtask

  task automatic test_async_reset();
    set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd7, 1'b1);
    tick();
    set_id(1'b1, 3'd7, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0);
    n_checks++; if ({stall, ex_dest_valid, ex_dest} !== 5'b11111) begin n_fail++; $display("FAIL arst_pre got %b want 11111", {stall, ex_dest_valid, ex_dest}); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if ({stall, ex_dest_valid} !== 2'b00) begin n_fail++; $display("FAIL arst_now got %b want 00", {stall, ex_dest_valid}); end
    n_checks++; if (stall_count !== 16'd0) begin n_fail++; $display("FAIL arst_count got %0d want 0", stall_count); end
    @(negedge clk); rst_n = 1'b1;
    set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1);
    tick();
    n_checks++; if ({ex_dest_valid, ex_dest} !== 4'b1011) begin n_fail++; $display("FAIL arst_first_load got %b want 1011", {ex_dest_valid, ex_dest}); end
    idle(); tick(); tick();
  endtask

  task automatic test_saturate();
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    // Each round: producer, then a consumer stalled for 2 cycles -> +2.
    for (int k = 0; k < 32767; k++) begin
      set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1); tick();
      set_id(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0); tick(); tick();
    end
    n_checks++; if (stall_count !== 16'hFFFE) begin n_fail++; $display("FAIL sat_preload got %h want FFFE", stall_count); end
    set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1); tick();
    set_id(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0); tick(); tick();
    set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1); tick();
    set_id(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0); tick();
    n_checks++; if (stall_count !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold got %h want FFFF", stall_count); end
    cnt_clr = 1'b1; #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL sat_clr_stall got %b want 1", stall); end
    tick(); cnt_clr = 1'b0;
    n_checks++; if (stall_count !== 16'h0000) begin n_fail++; $display("FAIL sat_clr got %h want 0000", stall_count); end
    idle(); tick();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_one_between();
    test_flush();
    test_mem_stall();
    test_both_match();
    test_async_reset();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
